game_input_conditioner: RTL

- Front-end stage feeding the game top level. Conditions the raw KEY/SW board inputs into clean control signals: `left`, `right`, shoot, and the cheat/mode switches.
- Per input: 2-flop synchronization, then counter-based debouncing.
- Shoot press edges become single-cycle fire pulses, with frame-paced auto-repeat while shoot is held or autofire is on.
- The game controller and shot logic consume these outputs in place of raw KEY/SW decoding.

---
 rtl/game_input_pkg.sv | 28 ++
 rtl/input_debouncer.sv | 43 ++++
 rtl/game_input_conditioner.sv | 121 ++++++++++++
 3 files changed

// File: rtl/game_input_pkg.sv
// Shared indices and types for the game input conditioner.
package game_input_pkg;

    localparam int KEY_RIGHT = 1;
    localparam int KEY_SHOOT = 2;
    localparam int KEY_LEFT  = 3;

    localparam int SW_AUTOFIRE = 0;
    localparam int SW_DAMAGE   = 7;
    localparam int SW_RAPID    = 8;
    localparam int SW_GOD      = 9;

    // Bit positions in the packed vector of conditioned inputs (pressed/on = 1).
    localparam int IN_LEFT    = 0;
    localparam int IN_RIGHT   = 1;
    localparam int IN_SHOOT   = 2;
    localparam int IN_AUTO    = 3;
    localparam int IN_DAMAGE  = 4;
    localparam int IN_RAPID   = 5;
    localparam int IN_GOD     = 6;
    localparam int NUM_INPUTS = 7;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } fire_state_t;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a counter debouncer; the state only
// changes after the synchronized input has differed for DEBOUNCE_CYCLES cycles.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            state  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            // Any return to the settled value restarts the count (glitch rejection).
            if (sync_2 == state) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                state <= ~state;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign dout = state;

endmodule

// File: rtl/game_input_conditioner.sv
// Conditions raw KEY/SW board inputs into debounced movement, switch levels
// and frame-paced fire pulses for the game controller.
//
// state | meaning
// IDLE  | fire source released; next rising edge fires immediately
// HOLD  | fire source held; repeat pulse every REPEAT_FRAMES frame strobes
module game_input_conditioner
    import game_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_FRAMES   = 8,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    input  logic       startOfFrame,
    output logic       left,
    output logic       right,
    output logic       shoot_hold,
    output logic       shoot_pulse,
    output logic       god_mode,
    output logic       rapid_fire,
    output logic       high_damage
);

    localparam int FRM_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(REPEAT_FRAMES - 1);

    logic [NUM_INPUTS-1:0] raw;
    logic [NUM_INPUTS-1:0] db;
    logic                  unused_inputs;

    // Keys are active-low on the board; flip them so every debouncer sees pressed = 1.
    assign raw[IN_LEFT]   = ~KEY[KEY_LEFT];
    assign raw[IN_RIGHT]  = ~KEY[KEY_RIGHT];
    assign raw[IN_SHOOT]  = ~KEY[KEY_SHOOT];
    assign raw[IN_AUTO]   = SW[SW_AUTOFIRE];
    assign raw[IN_DAMAGE] = SW[SW_DAMAGE];
    assign raw[IN_RAPID]  = SW[SW_RAPID];
    assign raw[IN_GOD]    = SW[SW_GOD];

    assign unused_inputs = ^{KEY[0], SW[6:1]};

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_db
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debouncer (
            .clk  (clk),
            .reset(reset),
            .din  (raw[i]),
            .dout (db[i])
        );
    end

    // Opposing directions cancel rather than picking a winner.
    assign left        = db[IN_LEFT] & ~db[IN_RIGHT];
    assign right       = db[IN_RIGHT] & ~db[IN_LEFT];
    assign god_mode    = db[IN_GOD];
    assign rapid_fire  = db[IN_RAPID];
    assign high_damage = db[IN_DAMAGE];

    logic        fire_src;
    fire_state_t state;
    fire_state_t state_n;
    logic [FRM_W-1:0] frm_cnt;
    logic [FRM_W-1:0] frm_cnt_n;
    logic        pulse;

    assign fire_src   = db[IN_SHOOT] | db[IN_AUTO];
    assign shoot_hold = fire_src;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            frm_cnt <= '0;
        end else begin
            state   <= state_n;
            frm_cnt <= frm_cnt_n;
        end
    end

    // startOfFrame is a registered strobe from the VGA controller on clk, so
    // gating it here keeps the pulse aligned to the frame cycle itself.
    always_comb begin
        state_n   = state;
        frm_cnt_n = frm_cnt;
        pulse     = 1'b0;
        case (state)
            IDLE: begin
                frm_cnt_n = '0;
                if (fire_src) begin
                    pulse   = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (!fire_src) begin
                    state_n   = IDLE;
                    frm_cnt_n = '0;
                end else if (startOfFrame) begin
                    if (frm_cnt == FRM_LAST) begin
                        pulse     = 1'b1;
                        frm_cnt_n = '0;
                    end else begin
                        frm_cnt_n = frm_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                frm_cnt_n = '0;
            end
        endcase
    end

    assign shoot_pulse = pulse;

endmodule
